// File: rtl/yolo_postproc_pkg.sv
// Shared constants, types and saturation helpers for the YOLO post-processing path.
package yolo_postproc_pkg;

   localparam int LEAKY_MUL          = 13;
   localparam int LEAKY_SHIFT        = 7;
   localparam int INT8_MIN           = -128;
   localparam int INT8_MAX           = 127;
   localparam int DEFAULT_PACK_LANES = 8;

   typedef logic [8*DEFAULT_PACK_LANES-1:0] packed_word_t;

   // 33-bit two's-complement sum clamped into the signed 32-bit range
   function automatic logic [31:0] sat32(input logic [32:0] v);
      if (v[32] != v[31]) begin
         return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return v[31:0];
   endfunction

   function automatic logic [7:0] sat_int8(input logic signed [49:0] v);
      if (v > $signed(50'(INT8_MAX))) begin
         return 8'(INT8_MAX);
      end
      if (v < $signed(50'(INT8_MIN))) begin
         return 8'(INT8_MIN);
      end
      return v[7:0];
   endfunction

endpackage

// File: rtl/postproc_out_fifo.sv
// First-word-fall-through buffer for packed words; a push into a full buffer
// succeeds only when a pop happens in the same cycle, otherwise it is dropped.
module postproc_out_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full;
   logic             pop;
   logic             wr_en;

   always_comb begin
      out_valid = (wr_ptr_q != rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop       = out_valid && pop_ready;
      wr_en     = push && (!full || pop);
      drop      = push && full && !pop;
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
      out_data  = out_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/quant_leaky_packer.sv
// Bias add, optional leaky ReLU, requantisation to int8, then packing of
// PACK_LANES lanes per word into an output FIFO.
module quant_leaky_packer
   import yolo_postproc_pkg::*;
#(
   parameter int PACK_LANES = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             acc_data_in,
   input  logic                    acc_valid_in,
   input  logic                    row_last_in,
   input  logic [31:0]             bias_in,
   input  logic [15:0]             scale_in,
   input  logic [5:0]              shift_in,
   input  logic                    leaky_en,
   output logic [8*PACK_LANES-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overflow_err,
   output logic                    busy
);
   localparam int W  = 8*PACK_LANES;
   localparam int CW = (PACK_LANES > 1) ? $clog2(PACK_LANES) : 1;
   localparam logic [CW-1:0]        LAST_LANE  = CW'(PACK_LANES-1);
   localparam logic signed [35:0]   LEAKY_MUL_S = 36'(LEAKY_MUL);

   logic              v1_q, v1_d, last1_q, last1_d;
   logic [31:0]       s1_q, s1_d;
   logic              v2_q, v2_d, last2_q, last2_d;
   logic [31:0]       s2_q, s2_d;
   logic              v3_q, v3_d, last3_q, last3_d;
   logic [48:0]       p_q, p_d;
   logic              v4_q, v4_d, last4_q, last4_d;
   logic [7:0]        r_q, r_d;
   logic [CW-1:0]     lane_cnt_q, lane_cnt_d;
   logic [W-1:0]      part_q, part_d;
   logic              ovf_q, ovf_d;

   logic signed [35:0] s1_ext, leaky_prod;
   logic signed [48:0] s2_ext, scale_ext;
   logic signed [49:0] p_ext, rnd, shifted;
   logic [W-1:0]       merged;
   logic               push;
   logic               drop;

   // Incoming lane overlays the partial word at the current lane position.
   for (genvar gi = 0; gi < PACK_LANES; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (lane_cnt_q == CW'(gi)) ? r_q : part_q[8*gi +: 8];
   end

   always_comb begin
      v1_d    = acc_valid_in;
      last1_d = acc_valid_in && row_last_in;
      s1_d    = sat32({acc_data_in[31], acc_data_in} + {bias_in[31], bias_in});

      v2_d       = v1_q;
      last2_d    = last1_q;
      s1_ext     = {{4{s1_q[31]}}, s1_q};
      leaky_prod = s1_ext * LEAKY_MUL_S;
      s2_d       = (leaky_en && s1_q[31]) ? 32'(leaky_prod >>> LEAKY_SHIFT) : s1_q;

      v3_d      = v2_q;
      last3_d   = last2_q;
      s2_ext    = {{17{s2_q[31]}}, s2_q};
      scale_ext = {33'd0, scale_in};
      p_d       = s2_ext * scale_ext;

      // Round half up, then arithmetic shift and clamp into int8
      v4_d    = v3_q;
      last4_d = last3_q;
      p_ext   = {p_q[48], p_q};
      rnd     = (shift_in != 6'd0) ? (50'sd1 <<< (shift_in - 6'd1)) : 50'sd0;
      shifted = (p_ext + rnd) >>> shift_in;
      r_d     = sat_int8(shifted);

      push       = v4_q && ((lane_cnt_q == LAST_LANE) || last4_q);
      part_d     = part_q;
      lane_cnt_d = lane_cnt_q;
      if (push) begin
         part_d     = '0;
         lane_cnt_d = '0;
      end else if (v4_q) begin
         part_d     = merged;
         lane_cnt_d = lane_cnt_q + CW'(1);
      end

      ovf_d = ovf_q || drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q       <= 1'b0;
         last1_q    <= 1'b0;
         s1_q       <= '0;
         v2_q       <= 1'b0;
         last2_q    <= 1'b0;
         s2_q       <= '0;
         v3_q       <= 1'b0;
         last3_q    <= 1'b0;
         p_q        <= '0;
         v4_q       <= 1'b0;
         last4_q    <= 1'b0;
         r_q        <= '0;
         lane_cnt_q <= '0;
         part_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         v1_q       <= v1_d;
         last1_q    <= last1_d;
         s1_q       <= s1_d;
         v2_q       <= v2_d;
         last2_q    <= last2_d;
         s2_q       <= s2_d;
         v3_q       <= v3_d;
         last3_q    <= last3_d;
         p_q        <= p_d;
         v4_q       <= v4_d;
         last4_q    <= last4_d;
         r_q        <= r_d;
         lane_cnt_q <= lane_cnt_d;
         part_q     <= part_d;
         ovf_q      <= ovf_d;
      end
   end

   postproc_out_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (merged),
      .pop_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .drop      (drop)
   );

   assign overflow_err = ovf_q;
   assign busy = v1_q || v2_q || v3_q || v4_q || (lane_cnt_q != '0) || out_valid;

endmodule

// File: tb/tb_quant_leaky_packer.sv
// Directed bench for quant_leaky_packer: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares every accepted output word.
module tb_quant_leaky_packer;
   import yolo_postproc_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  acc_data_in;
   logic         acc_valid_in;
   logic         row_last_in;
   logic [31:0]  bias_in;
   logic [15:0]  scale_in;
   logic [5:0]   shift_in;
   logic         leaky_en;
   packed_word_t out_data;
   logic         out_valid;
   logic         out_ready;
   logic         overflow_err;
   logic         busy;

   int           n_cmp  = 0;
   int           n_fail = 0;
   packed_word_t exp_q[$];
   packed_word_t mon_exp;

   quant_leaky_packer #(.PACK_LANES(8), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .acc_data_in  (acc_data_in),
      .acc_valid_in (acc_valid_in),
      .row_last_in  (row_last_in),
      .bias_in      (bias_in),
      .scale_in     (scale_in),
      .shift_in     (shift_in),
      .leaky_en     (leaky_en),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow_err (overflow_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %h, expected no word", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("word", out_data, mon_exp);
         end
      end
   end

   function automatic packed_word_t mkword(input int base, input int n);
      packed_word_t w = '0;
      for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(base + k);
      return w;
   endfunction

   task automatic send(input logic [31:0] a, input logic last);
      acc_data_in  = a;
      acc_valid_in = 1'b1;
      row_last_in  = last;
      @(posedge clk);
      #1;
      acc_valid_in = 1'b0;
      row_last_in  = 1'b0;
   endtask

   task automatic send_run(input int base, input int n);
      for (int k = 0; k < n; k++) send(32'(base + k), 1'b0);
   endtask

   task automatic cfg(input logic [31:0] b, input logic [15:0] s, input logic [5:0] sh, input logic lk);
      bias_in  = b;
      scale_in = s;
      shift_in = sh;
      leaky_en = lk;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, {63'd0, busy}, 64'd0);
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      acc_data_in  = '0;
      acc_valid_in = 1'b0;
      row_last_in  = 1'b0;
      out_ready    = 1'b1;
      cfg(32'd0, 16'd1, 6'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1..8 back-to-back; word appears 5 cycles after the 8th sample
      exp_q.push_back(64'h0807060504030201);
      send_run(1, 8);
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("latency_c%0d", c), {63'd0, out_valid}, (c == 5) ? 64'd1 : 64'd0);
         @(posedge clk);
         #1;
      end
      wait_idle("idle_after_seq");

      // Leaky ReLU on negative and positive input
      cfg(32'd0, 16'd1, 6'd0, 1'b1);
      exp_q.push_back(64'h000000000000009A);
      send(-32'sd1000, 1'b1);
      exp_q.push_back(64'h0000000000000064);
      send(32'd100, 1'b1);
      wait_idle("idle_after_leaky");

      // Rounding and int8 saturation
      cfg(32'd0, 16'd3, 6'd4, 1'b0);
      exp_q.push_back(64'h0000000000807F08);
      send(32'd40, 1'b0);
      send(32'd1000, 1'b0);
      send(-32'sd1000, 1'b1);
      wait_idle("idle_after_requant");

      // 32-bit bias saturation, both directions
      cfg(32'h0000_0100, 16'd1, 6'd24, 1'b0);
      exp_q.push_back(64'h000000000000007F);
      send(32'h7FFF_FFF0, 1'b1);
      wait_idle("idle_after_possat");
      cfg(32'hFFFF_FF00, 16'd1, 6'd24, 1'b0);
      exp_q.push_back(64'h0000000000000080);
      send(32'h8000_0010, 1'b1);
      wait_idle("idle_after_negsat");

      // Short row then a full word starting at lane 0
      cfg(32'd0, 16'd1, 6'd0, 1'b0);
      exp_q.push_back(64'h0000000000070605);
      send(32'd5, 1'b0);
      send(32'd6, 1'b0);
      send(32'd7, 1'b1);
      exp_q.push_back(64'h100F0E0D0C0B0A09);
      send_run(9, 8);
      wait_idle("idle_after_rowlast");

      // row_last without a valid sample must not close the word
      exp_q.push_back(64'h0807060504030201);
      send(32'd1, 1'b0);
      row_last_in = 1'b1;
      @(posedge clk);
      #1;
      row_last_in = 1'b0;
      send_run(2, 7);
      wait_idle("idle_after_stray_last");

      // Five words into a stalled 4-deep buffer: the fifth is dropped
      out_ready = 1'b0;
      for (int w = 0; w < 4; w++) exp_q.push_back(mkword(1 + 8*w, 8));
      send_run(1, 40);
      repeat (8) @(posedge clk);
      #1;
      chk("ovf_set", {63'd0, overflow_err}, 64'd1);
      chk("ovf_held_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      wait_drain("ovf_drain");
      chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
      wait_idle("idle_after_ovf");

      // Asynchronous reset with a stored word and a partial word
      out_ready = 1'b0;
      send_run(32'h21, 11);
      repeat (6) @(posedge clk);
      #1;
      chk("pre_rst_busy", {63'd0, busy}, 64'd1);
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_data", out_data, 64'd0);
      chk("async_rst_ovf", {63'd0, overflow_err}, 64'd0);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(64'h1817161514131211);
      send_run(32'h11, 8);
      wait_idle("idle_after_rst");

      // Push into a full buffer in the same cycle as a pop: nothing is lost
      out_ready = 1'b0;
      for (int w = 0; w < 5; w++) exp_q.push_back(mkword(32'h41 + 8*w, 8));
      send_run(32'h41, 40);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("full_pushpop_no_ovf", {63'd0, overflow_err}, 64'd0);
      out_ready = 1'b1;
      wait_drain("pushpop_drain");
      wait_idle("idle_final");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
